// File: rtl/sdram_burst_arbiter_pkg.sv
// Shared encodings for the SDRAM burst arbiter: FSM states and burst direction codes.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BURST   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // DIR_RD is 1 so the direction maps straight onto the SDRAM read/write select.
    typedef enum logic {
        DIR_WR = 1'b0,
        DIR_RD = 1'b1
    } arb_dir_t;

    function automatic arb_dir_t opposite_dir(input arb_dir_t d);
        return (d == DIR_WR) ? DIR_RD : DIR_WR;
    endfunction

endpackage

// File: rtl/sdram_burst_arbiter_if.sv
// Bundle of requester, VGA and SDRAM controller signals seen by the burst arbiter.
interface sdram_burst_arbiter_if #(
    parameter int PixelBitWidth     = 16,
    parameter int AddressWidthSDRAM = 24
) ();

    logic                         i_wr_req;
    logic [AddressWidthSDRAM-1:0] i_wr_addr;
    logic [PixelBitWidth-1:0]     i_wr_pixel;
    logic                         o_wr_ack;
    logic                         o_wr_next;

    logic                         i_rd_req;
    logic                         i_rd_urgent;
    logic [AddressWidthSDRAM-1:0] i_rd_addr;
    logic                         o_rd_ack;
    logic [PixelBitWidth-1:0]     o_rd_pixel;
    logic                         o_rd_valid;

    logic                         o_burst_done;

    logic                         i_sdram_busy;
    logic                         i_sdram_valid_wr;
    logic                         i_sdram_valid_rd;
    logic [PixelBitWidth-1:0]     i_sdram_pixel;
    logic                         o_sdram_enable;
    logic                         o_sdram_read;
    logic [AddressWidthSDRAM-1:0] o_sdram_addr;
    logic [PixelBitWidth-1:0]     o_sdram_pixel;

    logic                         o_timeout;

    // Arbiter side.
    modport slave (
        input  i_wr_req, i_wr_addr, i_wr_pixel,
        input  i_rd_req, i_rd_urgent, i_rd_addr,
        input  i_sdram_busy, i_sdram_valid_wr, i_sdram_valid_rd, i_sdram_pixel,
        output o_wr_ack, o_wr_next, o_rd_ack, o_rd_pixel, o_rd_valid, o_burst_done,
        output o_sdram_enable, o_sdram_read, o_sdram_addr, o_sdram_pixel, o_timeout
    );

    // Requesters plus SDRAM controller side.
    modport master (
        output i_wr_req, i_wr_addr, i_wr_pixel,
        output i_rd_req, i_rd_urgent, i_rd_addr,
        output i_sdram_busy, i_sdram_valid_wr, i_sdram_valid_rd, i_sdram_pixel,
        input  o_wr_ack, o_wr_next, o_rd_ack, o_rd_pixel, o_rd_valid, o_burst_done,
        input  o_sdram_enable, o_sdram_read, o_sdram_addr, o_sdram_pixel, o_timeout
    );

endinterface

// File: rtl/sdram_burst_arbiter_grant_select.sv
// Picks the next burst direction from pending requests and tracks the read-streak
// count and last granted direction; state advances only when the grant is taken.
import sdram_arb_pkg::*;

module sdram_grant_select #(
    parameter int MaxReadStreak = 4
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     wr_req,
    input  logic     rd_req,
    input  logic     rd_urgent,
    input  logic     take,
    output logic     grant_any,
    output arb_dir_t grant_dir
);

    localparam int SW = (MaxReadStreak > 0) ? $clog2(MaxReadStreak + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MaxReadStreak);

    logic [SW-1:0] streak_q;
    arb_dir_t      last_q;

    assign grant_any = wr_req | rd_req;

    // A starved writer beats an urgent reader; otherwise urgency, then alternation.
    always_comb begin
        grant_dir = DIR_WR;
        if (wr_req && (streak_q == STREAK_MAX)) begin
            grant_dir = DIR_WR;
        end else if (rd_urgent && rd_req) begin
            grant_dir = DIR_RD;
        end else if (wr_req && rd_req) begin
            grant_dir = opposite_dir(last_q);
        end else if (rd_req) begin
            grant_dir = DIR_RD;
        end else begin
            grant_dir = DIR_WR;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            streak_q <= '0;
            last_q   <= DIR_RD;
        end else if (take) begin
            last_q <= grant_dir;
            if (grant_dir == DIR_WR) begin
                streak_q <= '0;
            end else if (wr_req && (streak_q != STREAK_MAX)) begin
                streak_q <= streak_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Arbitrates UART write bursts and VGA read bursts onto a single SDRAM port,
// with a watchdog that abandons a stalled burst and raises a sticky error flag.
import sdram_arb_pkg::*;

module sdram_burst_arbiter #(
    parameter int PixelBitWidth     = 16,
    parameter int AddressWidthSDRAM = 24,
    parameter int BurstLengthSDRAM  = 8,
    parameter int MaxReadStreak     = 4,
    parameter int TimeoutCycles     = 1024
) (
    input  logic                 CLK,
    input  logic                 RST,
    sdram_burst_arbiter_if.slave bus
);

    localparam int BEAT_W = $clog2(BurstLengthSDRAM + 1);
    localparam int WD_W   = $clog2(TimeoutCycles + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BurstLengthSDRAM - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TimeoutCycles - 1);

    arb_state_t                   state_q;
    arb_dir_t                     dir_q;
    logic [BEAT_W-1:0]            beat_q;
    logic [WD_W-1:0]              wd_q;
    logic [AddressWidthSDRAM-1:0] addr_q;
    logic                         enable_q;
    logic                         read_q;
    logic                         wr_ack_q;
    logic                         rd_ack_q;
    logic                         done_q;
    logic                         timeout_q;

    logic [PixelBitWidth-1:0]     rd_pixel_p1;
    logic                         vld_p1;

    logic     grant_any;
    arb_dir_t grant_dir;
    logic     take;
    logic     beat_fire;

    assign take = (state_q == ST_IDLE) && !bus.i_sdram_busy && grant_any;

    // Only the granted direction's valid advances the beat count.
    assign beat_fire = (state_q == ST_BURST) &&
                       ((dir_q == DIR_WR) ? bus.i_sdram_valid_wr : bus.i_sdram_valid_rd);

    sdram_grant_select #(
        .MaxReadStreak (MaxReadStreak)
    ) u_grant (
        .CLK       (CLK),
        .RST       (RST),
        .wr_req    (bus.i_wr_req),
        .rd_req    (bus.i_rd_req),
        .rd_urgent (bus.i_rd_urgent),
        .take      (take),
        .grant_any (grant_any),
        .grant_dir (grant_dir)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_WR;
            beat_q    <= '0;
            wd_q      <= '0;
            addr_q    <= '0;
            enable_q  <= 1'b0;
            read_q    <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            wr_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
            done_q   <= 1'b0;
            if ((state_q != ST_IDLE) && (wd_q == WD_LAST)) begin
                // Stalled transaction: give up on it and flag the error permanently.
                state_q   <= ST_IDLE;
                beat_q    <= '0;
                wd_q      <= '0;
                enable_q  <= 1'b0;
                timeout_q <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        wd_q <= '0;
                        if (take) begin
                            state_q  <= ST_ISSUE;
                            dir_q    <= grant_dir;
                            read_q   <= (grant_dir == DIR_RD);
                            addr_q   <= (grant_dir == DIR_RD) ? bus.i_rd_addr : bus.i_wr_addr;
                            enable_q <= 1'b1;
                            wr_ack_q <= (grant_dir == DIR_WR);
                            rd_ack_q <= (grant_dir == DIR_RD);
                        end
                    end
                    ST_ISSUE: begin
                        if (bus.i_sdram_busy) begin
                            state_q  <= ST_BURST;
                            enable_q <= 1'b0;
                            wd_q     <= '0;
                        end else begin
                            wd_q <= wd_q + 1'b1;
                        end
                    end
                    ST_BURST: begin
                        if (beat_fire) begin
                            wd_q <= '0;
                            if (beat_q == LAST_BEAT) begin
                                beat_q  <= '0;
                                done_q  <= 1'b1;
                                state_q <= ST_RELEASE;
                            end else begin
                                beat_q <= beat_q + 1'b1;
                            end
                        end else begin
                            wd_q <= wd_q + 1'b1;
                        end
                    end
                    ST_RELEASE: begin
                        if (!bus.i_sdram_busy) begin
                            state_q <= ST_IDLE;
                            wd_q    <= '0;
                        end else begin
                            wd_q <= wd_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // p0 -> p1: read beat from SDRAM registered toward the VGA side
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_pixel_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= beat_fire && (dir_q == DIR_RD);
            if (beat_fire && (dir_q == DIR_RD)) begin
                rd_pixel_p1 <= bus.i_sdram_pixel;
            end
        end
    end

    assign bus.o_wr_ack       = wr_ack_q;
    assign bus.o_rd_ack       = rd_ack_q;
    assign bus.o_wr_next      = (state_q == ST_BURST) && (dir_q == DIR_WR) && bus.i_sdram_valid_wr;
    assign bus.o_rd_pixel     = rd_pixel_p1;
    assign bus.o_rd_valid     = vld_p1;
    assign bus.o_burst_done   = done_q;
    assign bus.o_sdram_enable = enable_q;
    assign bus.o_sdram_read   = read_q;
    assign bus.o_sdram_addr   = addr_q;
    assign bus.o_sdram_pixel  = bus.i_wr_pixel;
    assign bus.o_timeout      = timeout_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed bench for the SDRAM burst arbiter: reset, write/read bursts, grant order,
// watchdog timeout and asynchronous reset abort.
module tb_sdram_burst_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    sdram_burst_arbiter_if #(.PixelBitWidth(16), .AddressWidthSDRAM(24)) bus ();

    sdram_burst_arbiter #(
        .PixelBitWidth     (16),
        .AddressWidthSDRAM (24),
        .BurstLengthSDRAM  (8),
        .MaxReadStreak     (4),
        .TimeoutCycles     (1024)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish in time");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_wr_req = 0; bus.i_wr_addr = '0; bus.i_wr_pixel = '0;
        bus.i_rd_req = 0; bus.i_rd_urgent = 0; bus.i_rd_addr = '0;
        bus.i_sdram_busy = 0; bus.i_sdram_valid_wr = 0; bus.i_sdram_valid_rd = 0;
        bus.i_sdram_pixel = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        RST = 0;
        tick(); tick();
        RST = 1;
        tick();
    endtask

    // Serves one burst with requests left as the caller set them; reports what was granted.
    task automatic serve_burst(output logic got_ack, output logic got_rd, output logic got_done);
        got_ack = 0; got_rd = 0; got_done = 0;
        for (int k = 0; k < 10 && !got_ack; k++) begin
            tick();
            if (bus.o_wr_ack || bus.o_rd_ack) begin
                got_ack = 1;
                got_rd  = bus.o_rd_ack;
            end
        end
        if (got_ack) begin
            bus.i_sdram_busy = 1;
            tick();
            for (int b = 0; b < 8; b++) begin
                if (got_rd) bus.i_sdram_valid_rd = 1; else bus.i_sdram_valid_wr = 1;
                tick();
                if (bus.o_burst_done) got_done = 1;
            end
            bus.i_sdram_valid_rd = 0; bus.i_sdram_valid_wr = 0;
            bus.i_sdram_busy = 0;
            tick();
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.i_wr_pixel = 16'hBEEF;
        bus.i_wr_req   = 1;
        RST = 0;
        tick(); tick();
        n_checks++; if ({bus.o_wr_ack, bus.o_rd_ack, bus.o_wr_next, bus.o_rd_valid, bus.o_burst_done} !== 5'b0) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 00000", {bus.o_wr_ack, bus.o_rd_ack, bus.o_wr_next, bus.o_rd_valid, bus.o_burst_done}); end
        n_checks++; if ({bus.o_sdram_enable, bus.o_sdram_read, bus.o_timeout} !== 3'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000", {bus.o_sdram_enable, bus.o_sdram_read, bus.o_timeout}); end
        n_checks++; if (bus.o_sdram_addr !== 24'h0 || bus.o_rd_pixel !== 16'h0) begin
            n_fail++; $display("FAIL reset_data: addr %h pixel %h want 0", bus.o_sdram_addr, bus.o_rd_pixel); end
        n_checks++; if (bus.o_sdram_pixel !== 16'hBEEF) begin
            n_fail++; $display("FAIL reset_wr_pixel_pass: got %h want beef", bus.o_sdram_pixel); end
        bus.i_wr_req = 0;
        RST = 1;
        tick();
    endtask

    task automatic test_write_burst();
        apply_reset();
        bus.i_wr_req = 1; bus.i_wr_addr = 24'h000100;
        tick();
        n_checks++; if ({bus.o_wr_ack, bus.o_rd_ack, bus.o_sdram_enable, bus.o_sdram_read} !== 4'b1010) begin
            n_fail++; $display("FAIL wr_ack_issue: ack/rack/en/rd got %b want 1010", {bus.o_wr_ack, bus.o_rd_ack, bus.o_sdram_enable, bus.o_sdram_read}); end
        n_checks++; if (bus.o_sdram_addr !== 24'h000100) begin
            n_fail++; $display("FAIL wr_addr: got %h want 000100", bus.o_sdram_addr); end
        bus.i_wr_req = 0;
        tick();
        n_checks++; if ({bus.o_wr_ack, bus.o_sdram_enable} !== 2'b01) begin
            n_fail++; $display("FAIL wr_enable_hold: ack/en got %b want 01", {bus.o_wr_ack, bus.o_sdram_enable}); end
        bus.i_sdram_busy = 1;
        tick();
        n_checks++; if (bus.o_sdram_enable !== 1'b0) begin
            n_fail++; $display("FAIL wr_enable_drop: got %b want 0", bus.o_sdram_enable); end
        bus.i_sdram_valid_rd = 1;
        #1;
        n_checks++; if (bus.o_wr_next !== 1'b0) begin
            n_fail++; $display("FAIL wr_ignores_rd_valid: wr_next got %b want 0", bus.o_wr_next); end
        tick();
        bus.i_sdram_valid_rd = 0;
        n_checks++; if (bus.o_rd_valid !== 1'b0 || bus.o_burst_done !== 1'b0) begin
            n_fail++; $display("FAIL wr_no_rd_valid: rd_valid %b done %b want 0 0", bus.o_rd_valid, bus.o_burst_done); end
        for (int i = 0; i < 8; i++) begin
            bus.i_sdram_valid_wr = 1;
            bus.i_wr_pixel = 16'hA000 + 16'(i);
            #1;
            n_checks++; if (bus.o_wr_next !== 1'b1 || bus.o_sdram_pixel !== 16'hA000 + 16'(i)) begin
                n_fail++; $display("FAIL wr_beat%0d: next %b pixel %h want 1 %h", i, bus.o_wr_next, bus.o_sdram_pixel, 16'hA000 + 16'(i)); end
            tick();
            n_checks++; if (bus.o_burst_done !== (i == 7)) begin
                n_fail++; $display("FAIL wr_done_beat%0d: got %b want %b", i, bus.o_burst_done, (i == 7)); end
        end
        bus.i_sdram_valid_wr = 0;
        #1;
        n_checks++; if (bus.o_wr_next !== 1'b0) begin
            n_fail++; $display("FAIL wr_next_release: got %b want 0", bus.o_wr_next); end
        tick();
        n_checks++; if (bus.o_burst_done !== 1'b0) begin
            n_fail++; $display("FAIL wr_done_single: got %b want 0", bus.o_burst_done); end
        bus.i_sdram_busy = 0;
        tick();
    endtask

    task automatic test_read_burst();
        apply_reset();
        bus.i_rd_req = 1; bus.i_rd_addr = 24'h00ABCD;
        tick();
        n_checks++; if ({bus.o_rd_ack, bus.o_wr_ack, bus.o_sdram_enable, bus.o_sdram_read} !== 4'b1011) begin
            n_fail++; $display("FAIL rd_ack_issue: rack/wack/en/rd got %b want 1011", {bus.o_rd_ack, bus.o_wr_ack, bus.o_sdram_enable, bus.o_sdram_read}); end
        n_checks++; if (bus.o_sdram_addr !== 24'h00ABCD) begin
            n_fail++; $display("FAIL rd_addr: got %h want 00abcd", bus.o_sdram_addr); end
        bus.i_rd_req = 0;
        bus.i_sdram_busy = 1;
        tick();
        bus.i_sdram_valid_wr = 1;
        #1;
        n_checks++; if (bus.o_wr_next !== 1'b0) begin
            n_fail++; $display("FAIL rd_ignores_wr_valid: wr_next got %b want 0", bus.o_wr_next); end
        tick();
        bus.i_sdram_valid_wr = 0;
        for (int i = 0; i < 8; i++) begin
            bus.i_sdram_valid_rd = 1;
            bus.i_sdram_pixel = 16'h1230 + 16'(i);
            tick();
            n_checks++; if (bus.o_rd_valid !== 1'b1 || bus.o_rd_pixel !== 16'h1230 + 16'(i) || bus.o_burst_done !== (i == 7)) begin
                n_fail++; $display("FAIL rd_beat%0d: valid %b pixel %h done %b want 1 %h %b",
                                   i, bus.o_rd_valid, bus.o_rd_pixel, bus.o_burst_done, 16'h1230 + 16'(i), (i == 7)); end
        end
        bus.i_sdram_valid_rd = 0;
        tick();
        n_checks++; if (bus.o_rd_valid !== 1'b0 || bus.o_burst_done !== 1'b0) begin
            n_fail++; $display("FAIL rd_after_burst: valid %b done %b want 0 0", bus.o_rd_valid, bus.o_burst_done); end
        bus.i_sdram_busy = 0;
        tick();
    endtask

    task automatic test_dropped_req();
        int acks;
        apply_reset();
        acks = 0;
        bus.i_sdram_busy = 1;
        bus.i_wr_req = 1;
        tick(); acks += int'(bus.o_wr_ack);
        tick(); acks += int'(bus.o_wr_ack);
        bus.i_wr_req = 0;
        bus.i_sdram_busy = 0;
        for (int k = 0; k < 4; k++) begin
            tick(); acks += int'(bus.o_wr_ack) + int'(bus.o_rd_ack);
        end
        n_checks++; if (acks !== 0) begin
            n_fail++; $display("FAIL dropped_req_ack: got %0d acks want 0", acks); end
    endtask

    task automatic test_alternate();
        logic       a, r, d;
        logic [3:0] exp_rd;
        apply_reset();
        exp_rd = 4'b1010;
        bus.i_wr_req = 1; bus.i_rd_req = 1;
        for (int i = 0; i < 4; i++) begin
            serve_burst(a, r, d);
            n_checks++; if ({a, d, r} !== {1'b1, 1'b1, exp_rd[i]}) begin
                n_fail++; $display("FAIL alternate_grant%0d: ack/done/rd got %b want 11%b", i, {a, d, r}, exp_rd[i]); end
        end
        bus.i_wr_req = 0; bus.i_rd_req = 0;
        tick();
    endtask

    task automatic test_urgent_streak();
        logic       a, r, d;
        logic [9:0] exp_rd;
        apply_reset();
        exp_rd = 10'b0111101111;
        bus.i_wr_req = 1; bus.i_rd_req = 1; bus.i_rd_urgent = 1;
        for (int i = 0; i < 10; i++) begin
            serve_burst(a, r, d);
            n_checks++; if ({a, d, r} !== {1'b1, 1'b1, exp_rd[i]}) begin
                n_fail++; $display("FAIL urgent_grant%0d: ack/done/rd got %b want 11%b", i, {a, d, r}, exp_rd[i]); end
        end
        bus.i_wr_req = 0; bus.i_rd_req = 0; bus.i_rd_urgent = 0;
        tick();
    endtask

    task automatic test_timeout_and_abort();
        int   n;
        logic seen_done;
        apply_reset();
        bus.i_wr_req = 1; bus.i_wr_addr = 24'h000200;
        tick();
        n_checks++; if (bus.o_wr_ack !== 1'b1) begin
            n_fail++; $display("FAIL to_wr_ack: got %b want 1", bus.o_wr_ack); end
        bus.i_wr_req = 0;
        bus.i_sdram_busy = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.i_sdram_valid_wr = 1;
            tick();
        end
        bus.i_sdram_valid_wr = 0;
        n = 0; seen_done = 0;
        for (int k = 1; k <= 1100; k++) begin
            tick();
            if (bus.o_burst_done) seen_done = 1;
            if (bus.o_timeout) begin
                n = k;
                break;
            end
        end
        n_checks++; if (n !== 1024) begin
            n_fail++; $display("FAIL timeout_latency: got %0d cycles want 1024 (0 means never)", n); end
        n_checks++; if (seen_done !== 1'b0 || bus.o_sdram_enable !== 1'b0) begin
            n_fail++; $display("FAIL timeout_no_done: done %b en %b want 0 0", seen_done, bus.o_sdram_enable); end
        bus.i_sdram_busy = 0;
        bus.i_rd_req = 1; bus.i_rd_addr = 24'h000300;
        tick();
        n_checks++; if ({bus.o_rd_ack, bus.o_timeout, bus.o_sdram_read} !== 3'b111 || bus.o_sdram_addr !== 24'h000300) begin
            n_fail++; $display("FAIL after_timeout_read: rack/to/rd %b addr %h want 111 000300",
                               {bus.o_rd_ack, bus.o_timeout, bus.o_sdram_read}, bus.o_sdram_addr); end
        bus.i_rd_req = 0;
        bus.i_sdram_busy = 1;
        tick();
        bus.i_sdram_valid_rd = 1; bus.i_sdram_pixel = 16'h55AA;
        tick(); tick();
        bus.i_sdram_valid_rd = 0;
        n_checks++; if (bus.o_rd_valid !== 1'b1 || bus.o_rd_pixel !== 16'h55AA) begin
            n_fail++; $display("FAIL pre_abort_read: valid %b pixel %h want 1 55aa", bus.o_rd_valid, bus.o_rd_pixel); end
        #2;
        RST = 0;
        #1;
        n_checks++; if ({bus.o_timeout, bus.o_rd_valid, bus.o_sdram_read, bus.o_sdram_enable, bus.o_burst_done} !== 5'b0) begin
            n_fail++; $display("FAIL async_abort_ctrl: to/vld/rd/en/done got %b want 00000",
                               {bus.o_timeout, bus.o_rd_valid, bus.o_sdram_read, bus.o_sdram_enable, bus.o_burst_done}); end
        n_checks++; if (bus.o_rd_pixel !== 16'h0 || bus.o_sdram_addr !== 24'h0) begin
            n_fail++; $display("FAIL async_abort_data: pixel %h addr %h want 0 0", bus.o_rd_pixel, bus.o_sdram_addr); end
        bus.i_sdram_busy = 0;
        bus.i_rd_req = 1;
        tick(); tick();
        n_checks++; if (bus.o_rd_ack !== 1'b0 || bus.o_burst_done !== 1'b0) begin
            n_fail++; $display("FAIL ack_in_reset: rack %b done %b want 0 0", bus.o_rd_ack, bus.o_burst_done); end
        bus.i_rd_req = 0;
        RST = 1;
        tick(); tick();
        n_checks++; if (bus.o_rd_ack !== 1'b0 || bus.o_wr_ack !== 1'b0) begin
            n_fail++; $display("FAIL ack_after_reset_no_req: rack %b wack %b want 0 0", bus.o_rd_ack, bus.o_wr_ack); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_write_burst();
        test_read_burst();
        test_dropped_req();
        test_alternate();
        test_urgent_streak();
        test_timeout_and_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_burst_arbiter.md
SDRAM_BURST_ARBITER -- requirements
Module: sdram_burst_arbiter

Interface
REQ-001 SHALL have parameter PixelBitWidth, default 16, pixel/data width.
REQ-002 SHALL have parameter AddressWidthSDRAM, default 24, SDRAM address width.
REQ-003 SHALL have parameter BurstLengthSDRAM, default 8, data beats per burst.
REQ-004 SHALL have parameter MaxReadStreak, default 4, consecutive read grants allowed while a write is pending.
REQ-005 SHALL have parameter TimeoutCycles, default 1024, watchdog limit in cycles.
REQ-006 SHALL have port CLK  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port i_wr_req  input  1  write-burst request (UART side).
REQ-009 SHALL have port i_wr_addr  input  AddressWidthSDRAM  write burst start address.
REQ-010 SHALL have port i_wr_pixel  input  PixelBitWidth  current write pixel.
REQ-011 SHALL have port o_wr_ack  output  1  write request accepted, 1-cycle pulse.
REQ-012 SHALL have port o_wr_next  output  1  current i_wr_pixel consumed; present next.
REQ-013 SHALL have port i_rd_req  input  1  read-burst request (VGA side).
REQ-014 SHALL have port i_rd_urgent  input  1  VGA line buffer below watermark.
REQ-015 SHALL have port i_rd_addr  input  AddressWidthSDRAM  read burst start address.
REQ-016 SHALL have port o_rd_ack  output  1  read request accepted, 1-cycle pulse.
REQ-017 SHALL have port o_rd_pixel  output  PixelBitWidth  read pixel to VGA side.
REQ-018 SHALL have port o_rd_valid  output  1  o_rd_pixel valid this cycle.
REQ-019 SHALL have port o_burst_done  output  1  granted burst completed, 1-cycle pulse.
REQ-020 SHALL have port i_sdram_busy  input  1  SDRAM not idle.
REQ-021 SHALL have port i_sdram_valid_wr  input  1  SDRAM accepts a write beat.
REQ-022 SHALL have port i_sdram_valid_rd  input  1  SDRAM presents a read beat.
REQ-023 SHALL have port i_sdram_pixel  input  PixelBitWidth  read data from SDRAM.
REQ-024 SHALL have port o_sdram_enable  output  1  command to SDRAM.
REQ-025 SHALL have port o_sdram_read  output  1  1=read, 0=write command.
REQ-026 SHALL have port o_sdram_addr  output  AddressWidthSDRAM  latched burst address.
REQ-027 SHALL have port o_sdram_pixel  output  PixelBitWidth  write data (= i_wr_pixel).
REQ-028 SHALL have port o_timeout  output  1  sticky watchdog error flag.

Function
REQ-029 SHALL implement FSM IDLE->ISSUE->BURST->RELEASE->IDLE; direction and address latched on leaving IDLE.
REQ-030 SHALL sample requests only in IDLE with i_sdram_busy=0; grant order: (a) i_wr_req and streak==MaxReadStreak -> write; (b) i_rd_urgent and i_rd_req -> read; (c) both requests -> opposite of last granted direction; (d) single request -> it.
REQ-031 SHALL keep a read-streak counter: +1 (saturating at MaxReadStreak) per read grant while i_wr_req=1; cleared on every write grant.
REQ-032 SHALL pulse o_wr_ack/o_rd_ack on the first ISSUE cycle (1-cycle latency from granting sample); requester holds req/addr until ack; a request dropped before ack is never granted.
REQ-033 ISSUE SHALL drive o_sdram_enable=1, o_sdram_read=direction, o_sdram_addr=latched address until i_sdram_busy=1, then enter BURST with enable=0.
REQ-034 BURST SHALL count beats 0..BurstLengthSDRAM-1 on the valid of the granted direction only; the other direction's valid is ignored.
REQ-035 Write burst: o_wr_next = i_sdram_valid_wr (combinational, BURST+write only); o_sdram_pixel = i_wr_pixel at all times.
REQ-036 Read burst: o_rd_pixel/o_rd_valid SHALL be i_sdram_pixel/i_sdram_valid_rd registered one cycle.
REQ-037 o_burst_done SHALL pulse one cycle after the final beat is counted (coincides with final o_rd_valid); FSM then enters RELEASE and returns to IDLE on first cycle with i_sdram_busy=0.
REQ-038 Watchdog SHALL count cycles outside IDLE, cleared on every state change and counted beat; on reaching TimeoutCycles-1: o_timeout<=1, FSM->IDLE, beat counter cleared, no o_burst_done.
REQ-039 o_timeout SHALL clear only by reset; arbitration continues normally while set.

Reset
REQ-040 RST=0 SHALL immediately force IDLE, all counters 0, last-grant=read (first tie goes to write), o_timeout=0, every output 0 except combinational o_sdram_pixel.
REQ-041 RST asserted mid-burst SHALL abort with no o_burst_done; no acks issued until RST=1 and a new IDLE sample.

Structure
REQ-042 Package sdram_arb_pkg SHALL hold FSM state encodings and direction codes DIR_WR/DIR_RD; grant logic plus streak counter SHALL be sub-module sdram_grant_select.

Verification
REQ-043 Write to 0x000100 from idle: o_wr_ack 1 cycle after req, enable held until busy=1, 8 valid_wr -> 8 o_wr_next, o_burst_done 1 cycle after 8th.
REQ-044 Both non-urgent requests held from reset: grants W,R,W,R over 4 bursts.
REQ-045 i_rd_urgent=1 and both requests held: grants R,R,R,R,W,R,R,R,R,W.
REQ-046 Read burst, i_sdram_pixel 0x1230..0x1237: o_rd_pixel same sequence delayed 1 cycle, 8 o_rd_valid, done with the 8th.
REQ-047 valid stops after 3 write beats: o_timeout=1 after 1024 cycles, no done, IDLE, next read served; RST=0 mid-burst clears all asynchronously.
